seq_div16: RTL and testbench

SEQ_DIV16 -- requirements
Module: seq_div16

---
 rtl/seq_div16_if.sv | 23 ++
 rtl/seq_div16.sv | 115 +++++++++++
 tb/tb_seq_div16.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/seq_div16_if.sv
// seq_div16_if: request/result bundle for the 16/8 sequential divider.
//   master: drives start, dividend, divisor; observes busy, done, quotient, remainder, dbz
//   slave : the divider side of the same signals
interface seq_div16_if;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        dbz;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, dbz
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, dbz
    );
endinterface

// File: rtl/seq_div16.sv
// seq_div16: unsigned 16-bit by 8-bit restoring divider, one quotient bit per clock.
//   clk          : single clock, rising edge
//   rst          : synchronous active-high reset
//   bus.start    : request a division, honoured only in IDLE
//   bus.dividend : 16-bit numerator, captured on the accepting edge
//   bus.divisor  : 8-bit denominator, captured on the accepting edge
//   bus.busy     : high in RUN and DONE
//   bus.done     : one-cycle pulse, results valid while high
//   bus.quotient : 16-bit quotient (16'hFFFF on divide-by-zero)
//   bus.remainder: 8-bit remainder (dividend[7:0] on divide-by-zero)
//   bus.dbz      : divide-by-zero flag of the last completed operation
module seq_div16 (
    input  logic        clk,
    input  logic        rst,
    seq_div16_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e      state_q;
    logic [15:0] a_q;      // dividend bits still to shift out; quotient bits shift in at LSB
    logic [7:0]  b_q;
    logic [8:0]  p_q;      // partial remainder, one bit wider than the divisor
    logic [4:0]  cnt_q;
    logic        zero_q;   // captured divisor was zero

    logic        busy_q;
    logic        done_q;
    logic [15:0] quo_q;
    logic [7:0]  rem_q;
    logic        dbz_q;

    // One restoring step.
    logic [8:0]  p_shift;
    logic        ge;
    logic [8:0]  p_next;
    logic [15:0] a_next;

    always_comb begin
        p_shift = {p_q[7:0], a_q[15]};
        ge      = (p_shift >= {1'b0, b_q});
        p_next  = ge ? (p_shift - {1'b0, b_q}) : p_shift;
        a_next  = {a_q[14:0], ge};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
            zero_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_q     <= bus.dividend;
                        b_q     <= bus.divisor;
                        p_q     <= '0;
                        cnt_q   <= '0;
                        zero_q  <= (bus.divisor == 8'd0);
                        busy_q  <= 1'b1;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    if (zero_q) begin
                        // Zero divisor skips the iterations: DONE after a single RUN edge.
                        quo_q   <= 16'hFFFF;
                        rem_q   <= a_q[7:0];
                        dbz_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        p_q   <= p_next;
                        a_q   <= a_next;
                        cnt_q <= cnt_q + 5'd1;
                        if (cnt_q == 5'd15) begin
                            // Results become visible only here, never mid-iteration.
                            quo_q   <= a_next;
                            rem_q   <= p_next[7:0];
                            dbz_q   <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.quotient  = quo_q;
    assign bus.remainder = rem_q;
    assign bus.dbz       = dbz_q;

endmodule

// File: tb/tb_seq_div16.sv
// tb_seq_div16: directed and random checks of seq_div16 against an arithmetic timing model.
module tb_seq_div16;

    localparam int unsigned NumRandom = 2000;

    logic clk = 1'b0;
    logic rst;

    seq_div16_if bus ();

    seq_div16 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Model: on accept, remember operands and a latency; when it runs out, publish a/b, a%b.
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic        m_dbz  = 1'b0;
    logic [15:0] m_q    = '0;
    logic [7:0]  m_r    = '0;
    logic [15:0] m_a    = '0;
    logic [7:0]  m_b    = '0;
    int          m_left = 0;
    bit          chk_en = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_dbz  = 1'b0;
            m_q    = '0;
            m_r    = '0;
            m_left = 0;
        end else if (!m_busy) begin
            if (bus.start) begin
                m_busy = 1'b1;
                m_a    = bus.dividend;
                m_b    = bus.divisor;
                m_left = (bus.divisor == 8'd0) ? 1 : 16;
            end
        end else if (m_done) begin
            m_done = 1'b0;
            m_busy = 1'b0;
        end else begin
            m_left--;
            if (m_left == 0) begin
                m_done = 1'b1;
                if (m_b == 8'd0) begin
                    m_q   = 16'hFFFF;
                    m_r   = m_a[7:0];
                    m_dbz = 1'b1;
                end else begin
                    m_q   = 16'(m_a / 16'(m_b));
                    m_r   = 8'(m_a % 16'(m_b));
                    m_dbz = 1'b0;
                end
            end
        end
    end

    bit spacing_en = 1'b0;
    bit have_last  = 1'b0;
    int last_done  = 0;
    int rand_dones = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            n_vec++;
            if ({bus.busy, bus.done, bus.dbz, bus.quotient, bus.remainder} !==
                {m_busy, m_done, m_dbz, m_q, m_r}) begin
                n_bad++;
                $display("FAIL model cyc %0d: got busy=%b done=%b dbz=%b q=%h r=%h, expected busy=%b done=%b dbz=%b q=%h r=%h",
                         cyc, bus.busy, bus.done, bus.dbz, bus.quotient, bus.remainder,
                         m_busy, m_done, m_dbz, m_q, m_r);
            end
            if (!spacing_en) have_last = 1'b0;
            if (bus.done === 1'b1) begin
                if (m_b != 8'd0) begin
                    check("identity", 32'(bus.quotient) * 32'(m_b) + 32'(bus.remainder), 32'(m_a));
                    check("rem_lt_div", 32'(bus.remainder < m_b), 32'd1);
                end
                if (spacing_en) begin
                    if (have_last) check("spacing", 32'(cyc - last_done), 32'd18);
                    have_last  = 1'b1;
                    last_done  = cyc;
                    rand_dones = rand_dones + 1;
                end
            end
        end
    end

    task automatic issue(input logic [15:0] a, input logic [7:0] b, output int k);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk);
        #1;
        k            = cyc;
        bus.start    = 1'b0;
        bus.dividend = 16'($urandom);
        bus.divisor  = 8'($urandom);
    endtask

    // Leaves the caller at the negedge where done was seen; lat = -1 on timeout.
    task automatic wait_done(input int k, output int lat);
        lat = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                lat = cyc - k;
                return;
            end
        end
    endtask

    task automatic run_op(input string name, input logic [15:0] a, input logic [7:0] b,
                          input logic [15:0] eq, input logic [7:0] er, input logic ed,
                          input int elat);
        int k;
        int lat;
        issue(a, b, k);
        wait_done(k, lat);
        check({name, "_lat"}, 32'(lat), 32'(elat));
        check({name, "_q"}, 32'(bus.quotient), 32'(eq));
        check({name, "_r"}, 32'(bus.remainder), 32'(er));
        check({name, "_dbz"}, 32'(bus.dbz), 32'(ed));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  k;
        int  lat;
        bit  saw_done;

        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_q", 32'(bus.quotient), 32'd0);
        check("rst_r", 32'(bus.remainder), 32'd0);
        check("rst_dbz", 32'(bus.dbz), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_op("d1000_7", 16'h03E8, 8'h07, 16'h008E, 8'h06, 1'b0, 16);
        run_op("ffff_ff", 16'hFFFF, 8'hFF, 16'h0101, 8'h00, 1'b0, 16);
        run_op("ffff_01", 16'hFFFF, 8'h01, 16'hFFFF, 8'h00, 1'b0, 16);
        run_op("dbz", 16'h1234, 8'h00, 16'hFFFF, 8'h34, 1'b1, 1);
        run_op("zero_5", 16'h0000, 8'h05, 16'h0000, 8'h00, 1'b0, 16);
        run_op("c8_c9", 16'h00C8, 8'hC9, 16'h0000, 8'hC8, 1'b0, 16);

        // Second start mid-RUN must be ignored.
        issue(16'h0064, 8'h0A, k);
        repeat (4) @(posedge clk);
        #1;
        bus.start    = 1'b1;
        bus.dividend = 16'h0001;
        bus.divisor  = 8'h01;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(k, lat);
        check("ignore_lat", 32'(lat), 32'd16);
        check("ignore_q", 32'(bus.quotient), 32'h000A);
        check("ignore_r", 32'(bus.remainder), 32'h00);
        @(posedge clk);
        #1;

        // Reset in the middle of RUN aborts without a done pulse.
        issue(16'hABCD, 8'h0D, k);
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_q", 32'(bus.quotient), 32'd0);
        saw_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) saw_done = 1'b1;
        end
        check("abort_no_done", 32'(saw_done), 32'd0);
        @(posedge clk);
        #1;
        run_op("after_abort", 16'hABCD, 8'h0D, 16'h0D37, 8'h02, 1'b0, 16);

        // Start held high with operands changing every cycle.
        spacing_en = 1'b1;
        bus.start  = 1'b1;
        for (int i = 0; i < int'(NumRandom) * 18 + 40 && rand_dones < int'(NumRandom); i++) begin
            @(posedge clk);
            #1;
            bus.dividend = 16'($urandom);
            bus.divisor  = 8'($urandom_range(1, 255));
        end
        bus.start = 1'b0;
        check("rand_count", 32'(rand_dones), 32'(NumRandom));
        spacing_en = 1'b0;
        for (int i = 0; i < 40 && bus.busy === 1'b1; i++) @(posedge clk);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
